// File: rtl/exe_stage.sv
// Execute stage of the 5-stage LoongArch pipeline.
// Holds one instruction from decode, computes its ALU result, issues the
// data SRAM request for loads/stores and hands the result to memory stage.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 150,
  parameter int ES_TO_MS_BUS_WD = 71
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  localparam int NUM_OPS = 12;

  logic                       es_valid_reg;
  logic [DS_TO_ES_BUS_WD-1:0] es_bus_reg;
  logic                       es_ready_go;

  // Fields of the registered decode bus
  logic [NUM_OPS-1:0] alu_op;
  logic               res_from_mem;
  logic               src1_is_pc;
  logic               src2_is_imm;
  logic               gr_we;
  logic               mem_we;
  logic [4:0]         dest;
  logic [31:0]        imm;
  logic [31:0]        rj_value;
  logic [31:0]        rkd_value;
  logic [31:0]        pc;

  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  shamt;
  logic [31:0] op_res    [NUM_OPS];
  logic [31:0] op_masked [NUM_OPS];
  logic [31:0] alu_result;
  logic        mem_go;

  assign alu_op       = es_bus_reg[149:138];
  assign res_from_mem = es_bus_reg[137];
  assign src1_is_pc   = es_bus_reg[136];
  assign src2_is_imm  = es_bus_reg[135];
  assign gr_we        = es_bus_reg[134];
  assign mem_we       = es_bus_reg[133];
  assign dest         = es_bus_reg[132:128];
  assign imm          = es_bus_reg[127:96];
  assign rj_value     = es_bus_reg[95:64];
  assign rkd_value    = es_bus_reg[63:32];
  assign pc           = es_bus_reg[31:0];

  // Execute always completes in one cycle
  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid_reg || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid_reg && es_ready_go;

  // Stage occupancy: cleared by reset, refilled whenever the stage can accept
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_reg <= 1'b0;
    end else if (es_allowin) begin
      es_valid_reg <= ds_to_es_valid;
    end
  end

  // Payload register; left unreset because es_valid_reg gates every use of it
  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) begin
      es_bus_reg <= ds_to_es_bus;
    end
  end

  assign src1  = src1_is_pc  ? pc  : rj_value;
  assign src2  = src2_is_imm ? imm : rkd_value;
  assign shamt = src2[4:0];

  assign op_res[0]  = src1 + src2;
  assign op_res[1]  = src1 - src2;
  assign op_res[2]  = {31'b0, $signed(src1) < $signed(src2)};
  assign op_res[3]  = {31'b0, src1 < src2};
  assign op_res[4]  = src1 & src2;
  assign op_res[5]  = ~(src1 | src2);
  assign op_res[6]  = src1 | src2;
  assign op_res[7]  = src1 ^ src2;
  assign op_res[8]  = src1 << shamt;
  assign op_res[9]  = src1 >> shamt;
  assign op_res[10] = $unsigned($signed(src1) >>> shamt);
  assign op_res[11] = src2;

  // Each op result is kept only if its one-hot select bit is set
  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_mask
      assign op_masked[gi] = op_res[gi] & {32{alu_op[gi]}};
    end
  endgenerate

  // OR-combine the masked results; an all-zero alu_op yields zero
  always_comb begin
    alu_result = 32'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      alu_result = alu_result | op_masked[i];
    end
  end

  // SRAM request fires only in the cycle the instruction moves on, so a
  // stalled instruction never issues a duplicate access
  assign mem_go          = es_valid_reg && ms_allowin;
  assign data_sram_en    = mem_go && (res_from_mem || mem_we);
  assign data_sram_we    = {4{mem_go && mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  assign es_to_ms_bus = {res_from_mem, gr_we, dest, alu_result, pc};

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: the stimulus process pushes the expected
// memory-stage payload when an instruction is accepted; the monitor pops and
// compares whenever the stage hands an instruction on.
module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [149:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ms_allowin      (ms_allowin),
    .es_allowin      (es_allowin),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_to_es_bus    (ds_to_es_bus),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [70:0] bus;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic occ      = 1'b0;   // model: stage holds an instruction this cycle
  logic occ_next = 1'b0;
  logic clear_pending = 1'b0;
  logic mon_en   = 1'b0;

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [149:0] mk(input int op, input logic rfm, input logic s1pc,
                                      input logic s2imm, input logic gwe, input logic mwe,
                                      input logic [4:0] dst, input logic [31:0] im,
                                      input logic [31:0] rj, input logic [31:0] rkd,
                                      input logic [31:0] p);
    logic [11:0] oh;
    oh = (op >= 0 && op < 12) ? (12'd1 << op) : 12'd0;
    return {oh, rfm, s1pc, s2imm, gwe, mwe, dst, im, rj, rkd, p};
  endfunction

  // Reference ALU from the instruction semantics
  function automatic logic [31:0] ref_alu(input logic [149:0] b);
    logic [31:0] a, c;
    logic [11:0] op;
    int sh, idx;
    a  = b[136] ? b[31:0] : b[95:64];
    c  = b[135] ? b[127:96] : b[63:32];
    op = b[149:138];
    sh = int'(c % 32);
    idx = -1;
    for (int i = 0; i < 12; i++) if (op[i]) idx = i;
    case (idx)
      0:  return a + c;
      1:  return a - c;
      2:  return (signed'(a) < signed'(c)) ? 32'd1 : 32'd0;
      3:  return (a < c) ? 32'd1 : 32'd0;
      4:  return a & c;
      5:  return ~(a | c);
      6:  return a | c;
      7:  return a ^ c;
      8:  return a << sh;
      9:  return a >> sh;
      10: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      11: return c;
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle of stimulus; res is the required ALU result
  task automatic step(input logic v, input logic [149:0] b, input logic ma,
                      input logic rst, input logic [31:0] res);
    logic accept;
    exp_t e;
    @(posedge clk);
    #1;
    occ = occ_next;
    if (clear_pending) sb_q.delete();
    clear_pending  = 1'b0;
    mon_en         = 1'b1;
    reset          = rst;
    ds_to_es_valid = v;
    ds_to_es_bus   = b;
    ms_allowin     = ma;
    if (rst) begin
      occ_next      = 1'b0;
      clear_pending = 1'b1;
    end else begin
      accept = v && (!occ || ma);
      if (accept) begin
        e.bus   = {b[137], b[134], b[132:128], res, b[31:0]};
        e.en    = b[137] | b[133];
        e.we    = {4{b[133]}};
        e.addr  = res;
        e.wdata = b[63:32];
        sb_q.push_back(e);
      end
      occ_next = accept ? 1'b1 : ((occ && ma) ? 1'b0 : occ);
    end
  endtask

  // Monitor: compare handshake and, on hand-off, the scoreboard head
  always @(negedge clk) begin
    if (mon_en) begin
      check("es_to_ms_valid", 71'(es_to_ms_valid), 71'(occ));
      check("es_allowin", 71'(es_allowin), 71'(!occ || ms_allowin));
      if (occ) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: valid output got none expected");
        end else begin
          check("es_to_ms_bus", es_to_ms_bus, sb_q[0].bus);
          if (ms_allowin) begin
            check("sram_en", 71'(data_sram_en), 71'(sb_q[0].en));
            check("sram_we", 71'(data_sram_we), 71'(sb_q[0].we));
            if (sb_q[0].en) begin
              check("sram_addr", 71'(data_sram_addr), 71'(sb_q[0].addr));
              check("sram_wdata", 71'(data_sram_wdata), 71'(sb_q[0].wdata));
            end
            $display("txn pc=%h result=%h en=%b we=%h", es_to_ms_bus[31:0],
                     es_to_ms_bus[63:32], data_sram_en, data_sram_we);
            void'(sb_q.pop_front());
          end else begin
            check("stall_sram_en", 71'(data_sram_en), 71'(0));
            check("stall_sram_we", 71'(data_sram_we), 71'(0));
          end
        end
      end else begin
        check("idle_sram_en", 71'(data_sram_en), 71'(0));
        check("idle_sram_we", 71'(data_sram_we), 71'(0));
      end
    end
  end

  initial begin
    logic [149:0] b;
    logic [149:0] nop;
    int k;
    reset = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_to_es_bus = '0;
    ms_allowin = 1'b1;
    nop = '0;

    // Reset held 3 cycles with valid input present
    repeat (3) step(1'b1, mk(0,0,0,0,1,0,5'd1,0,1,2,0), 1'b1, 1'b1, 32'd0);
    step(1'b0, nop, 1'b1, 1'b0, 32'd0);

    // add.w overflow wrap
    step(1'b1, mk(0,0,0,0,1,0,5'd5,0,32'h7FFF_FFFF,32'd1,32'h1C00_0000), 1'b1, 1'b0, 32'h8000_0000);
    // slt / sltu
    step(1'b1, mk(2,0,0,0,1,0,5'd6,0,32'hFFFF_FFFF,32'd1,32'h1C00_0004), 1'b1, 1'b0, 32'd1);
    step(1'b1, mk(3,0,0,0,1,0,5'd7,0,32'hFFFF_FFFF,32'd1,32'h1C00_0008), 1'b1, 1'b0, 32'd0);
    // srai / srli / slli
    step(1'b1, mk(10,0,0,1,1,0,5'd8,32'd4,32'h8000_0000,0,32'h1C00_000C), 1'b1, 1'b0, 32'hF800_0000);
    step(1'b1, mk(9,0,0,1,1,0,5'd9,32'd4,32'h8000_0000,0,32'h1C00_0010), 1'b1, 1'b0, 32'h0800_0000);
    step(1'b1, mk(8,0,0,1,1,0,5'd10,32'd31,32'd1,0,32'h1C00_0014), 1'b1, 1'b0, 32'h8000_0000);
    step(1'b0, nop, 1'b1, 1'b0, 32'd0);

    // st.w then an idle cycle (en must drop after one cycle)
    step(1'b1, mk(0,0,0,1,0,1,5'd0,32'hFFFF_FFFC,32'h1000,32'hDEAD_BEEF,32'h1C00_0018), 1'b1, 1'b0, 32'h0000_0FFC);
    step(1'b0, nop, 1'b1, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b0, 32'd0);

    // ld.w stalled two cycles with competing input, then released
    step(1'b1, mk(0,1,0,1,1,0,5'd11,32'd8,32'h2000,32'h5555,32'h1C00_001C), 1'b1, 1'b0, 32'h0000_2008);
    step(1'b1, mk(7,0,0,0,1,0,5'd12,0,32'h1,32'h2,32'h1C00_0020), 1'b0, 1'b0, 32'd3);
    step(1'b1, mk(7,0,0,0,1,0,5'd12,0,32'h1,32'h2,32'h1C00_0020), 1'b0, 1'b0, 32'd3);
    step(1'b0, nop, 1'b1, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b0, 32'd0);

    // Back-to-back addi.w stream, then jirl-style pc+4
    for (int i = 1; i <= 4; i++)
      step(1'b1, mk(0,0,0,1,1,0,5'(i),32'(i),32'h10,0,32'h1C00_0100 + 32'(4*i)), 1'b1, 1'b0, 32'h10 + 32'(i));
    step(1'b1, mk(0,0,1,1,1,0,5'd1,32'd4,32'h0,0,32'h1C00_0000), 1'b1, 1'b0, 32'h1C00_0004);
    step(1'b0, nop, 1'b1, 1'b0, 32'd0);

    // Randomized traffic with stalls and occasional mid-run resets
    for (int n = 0; n < 400; n++) begin
      k = int'($urandom_range(0, 12));
      b = mk(k, ($urandom_range(0,3) == 0), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,1), ($urandom_range(0,3) == 0), 5'($urandom),
             $urandom, $urandom, $urandom, $urandom);
      step($urandom_range(0,3) != 0, b, $urandom_range(0,2) != 0,
           $urandom_range(0,49) == 0, ref_alu(b));
    end

    // Drain
    repeat (3) step(1'b0, nop, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    check("queue_drained", 71'(sb_q.size()), 71'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
